regfile_mp_scoreboard: RTL and testbench
========================================

// Module: regfile_mp_scoreboard
// PURPOSE
//  Parametrised multi-port integer register file for the RV32I core, replacing the fixed 2R/1W file.
//  Adds N write ports with deterministic collision priority, optional write-to-read bypass,
//  and a per-register pending-write scoreboard (busy bits) used by issue logic to stall hazards.
//  Sits between decode/issue (read + allocate) and writeback (write ports).
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   register address width; depth = 2**ADDR_W
//  NUM_RD   2   number of read ports
//  NUM_WR   2   number of write ports
//  BYPASS   1   1 = same-cycle write data forwarded to reads; 0 = reads see registered state only
// PORTS
//  i_clk         in   1               clock, all state updates on rising edge
//  i_rst         in   1               asynchronous reset, active-high
//  i_rd_addr     in   NUM_RD*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//  o_rd_data     out  NUM_RD*DATA_W   read data, port k at [k*DATA_W +: DATA_W]
//  o_rd_busy     out  NUM_RD          1 = register on port k has a pending (allocated, unwritten) write
//  i_wr_addr     in   NUM_WR*ADDR_W   write addresses
//  i_wr_data     in   NUM_WR*DATA_W   write data
//  i_wr_wren     in   NUM_WR          per-port write enable
//  i_alloc_en    in   1               mark i_alloc_addr as pending producer
//  i_alloc_addr  in   ADDR_W          register being allocated
//  i_flush       in   1               clear all busy bits (pipeline squash)
//  o_busy_cnt    out  ADDR_W+1        registered count of busy registers
// BEHAVIOUR
//  - Reset (async, i_rst=1): all registers = 0, all busy bits = 0, o_busy_cnt = 0; holds while asserted.
//  - Register 0: always reads 0, never busy; writes and allocs to address 0 ignored.
//  - Write: on rising edge, reg[a] <= data for each enabled port with a != 0.
//    Same address on several enabled ports: highest port index wins; others discarded.
//  - Read: combinational, zero latency. BYPASS=1: if any enabled write port targets the read address
//    (!=0) this cycle, o_rd_data = winning write data; else registered value. BYPASS=0: registered value.
//  - Busy set: rising edge with i_alloc_en=1, i_alloc_addr!=0 -> busy[i_alloc_addr] <= 1.
//  - Busy clear: rising edge with enabled write to a -> busy[a] <= 0.
//  - Same-cycle alloc + write to same address: alloc wins, busy stays 1 (new producer outstanding).
//  - i_flush: all busy bits <= 0 at the edge; simultaneous alloc still sets its bit (flush, then alloc).
//  - o_rd_busy[k] = busy[addr_k]; BYPASS=1 and a same-cycle write to addr_k -> reports 0
//    unless the same cycle also allocates addr_k.
//  - Alloc of an already-busy register: stays busy, count unchanged (no nesting/counter per register).
//  - o_busy_cnt: popcount of busy bits after the edge, registered; range 0..2**ADDR_W-1.
//  - Reset asserted mid-operation aborts all pending writes; no partial update survives.
// STRUCTURE
//  - Package regfile_pkg: DATA_W/ADDR_W defaults, typedef reg_addr_t, reg_data_t, constant REG_ZERO.
//  - Sub-module rf_write_resolve: per-address winning-port select (highest index) producing
//    write-enable vector, winning data per address; reused by storage update and bypass path.
//  - Storage, busy vector and busy counter in the top; read muxes via generate over NUM_RD.
// TESTING
//  - Reset: write x5=0xDEAD, assert i_rst mid-cycle -> x5 reads 0, all o_rd_busy=0, o_busy_cnt=0.
//  - Collision: port0 x7=0x1111, port1 x7=0x2222 same edge -> next cycle x7 reads 0x2222.
//  - Bypass: BYPASS=1, read x3 while port0 writes x3=0xABCD -> o_rd_data=0xABCD same cycle;
//    BYPASS=0 build -> old value, 0xABCD one cycle later.
//  - x0: write x0=0xFFFF_FFFF, alloc x0 -> x0 reads 0, o_rd_busy=0, o_busy_cnt unchanged.
//  - Scoreboard: alloc x4, x9 -> o_busy_cnt=2; write x4 -> busy[4]=0, cnt=1;
//    alloc x9 + write x9 same edge -> busy[9] stays 1, cnt=1.
//  - Flush: 3 busy registers, i_flush with alloc x12 same edge -> only x12 busy, o_busy_cnt=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
// Holds the default geometry of the RV32I file, the address/data types
// used by code that works at the default widths, and the hard-wired
// zero register address.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

  // x0 is hard-wired to zero and can never become a pending producer
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_write_resolve.sv
// Per-address write resolution for the register file.
// Decodes all write ports into a one-hot-per-address write-enable vector
// and the winning data for each address. When several enabled ports hit
// the same address, the highest port index wins. Address 0 is never
// enabled. The same result feeds both storage update and the bypass path.
//
// Ports:
//   wr_addr     in   NUM_WR*ADDR_W    write addresses, port p at [p*ADDR_W +: ADDR_W]
//   wr_data     in   NUM_WR*DATA_W    write data, port p at [p*DATA_W +: DATA_W]
//   wr_wren     in   NUM_WR           per-port write enable
//   addr_wen    out  2**ADDR_W        1 = address is written this cycle
//   addr_wdata  out  2**ADDR_W*DATA_W winning data, address a at [a*DATA_W +: DATA_W]
module rf_write_resolve
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_WR = 2
) (
  input  logic [NUM_WR*ADDR_W-1:0]        wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]        wr_data,
  input  logic [NUM_WR-1:0]               wr_wren,
  output logic [(2**ADDR_W)-1:0]          addr_wen,
  output logic [(2**ADDR_W)*DATA_W-1:0]   addr_wdata
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  // Ports are scanned in ascending order so a later (higher-index) port
  // simply overwrites an earlier one that targeted the same address.
  always_comb begin
    logic [ADDR_W-1:0] wa;
    addr_wen   = '0;
    addr_wdata = '0;
    wa         = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wa = wr_addr[p*ADDR_W +: ADDR_W];
      if (wr_wren[p] && (wa != ZERO_ADDR)) begin
        addr_wen[wa]                   = 1'b1;
        addr_wdata[wa*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with pending-write scoreboard.
// Storage, per-register busy bits and a registered busy count live here.
// Issue logic allocates a destination (sets busy), writeback ports write
// data (clear busy), and a flush squashes every pending producer.
//
// Ports:
//   i_clk         in   1               clock, rising edge
//   i_rst         in   1               asynchronous reset, active-high
//   i_rd_addr     in   NUM_RD*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//   o_rd_data     out  NUM_RD*DATA_W   read data, port k at [k*DATA_W +: DATA_W]
//   o_rd_busy     out  NUM_RD          pending-write flag of the register read on port k
//   i_wr_addr     in   NUM_WR*ADDR_W   write addresses
//   i_wr_data     in   NUM_WR*DATA_W   write data
//   i_wr_wren     in   NUM_WR          per-port write enable
//   i_alloc_en    in   1               mark i_alloc_addr as pending producer
//   i_alloc_addr  in   ADDR_W          register being allocated
//   i_flush       in   1               clear all busy bits
//   o_busy_cnt    out  ADDR_W+1        registered count of busy registers
module regfile_mp_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic [NUM_WR-1:0]        i_wr_wren,
  input  logic                     i_alloc_en,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  input  logic                     i_flush,
  output logic [ADDR_W:0]          o_busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0]        wen_vec;
  logic [DEPTH*DATA_W-1:0] wdata_flat;
  logic [DATA_W-1:0]       regs [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic [DEPTH-1:0]        busy_next;
  logic [ADDR_W:0]         busy_cnt;
  logic [ADDR_W:0]         busy_cnt_next;
  logic                    alloc_valid;

  rf_write_resolve #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_write_resolve (
    .wr_addr    (i_wr_addr),
    .wr_data    (i_wr_data),
    .wr_wren    (i_wr_wren),
    .addr_wen   (wen_vec),
    .addr_wdata (wdata_flat)
  );

  assign alloc_valid = i_alloc_en && (i_alloc_addr != ZERO_ADDR);

  // Busy update order: flush, then writes clear, then alloc sets. Applying
  // alloc last lets a new producer win over a retiring one on the same
  // register, and lets an alloc survive a simultaneous flush.
  always_comb begin
    busy_next = i_flush ? '0 : busy;
    busy_next = busy_next & ~wen_vec;
    if (alloc_valid) begin
      busy_next[i_alloc_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // The count is taken from the next-state vector so the registered value
  // always matches the busy bits after the same edge.
  always_comb begin
    busy_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_next = busy_cnt_next + (ADDR_W+1)'(busy_next[i]);
    end
  end

  // State update. Reset clears everything and overrides any write that
  // was in flight, so no partial update survives an aborted cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wen_vec[i]) begin
          regs[i] <= wdata_flat[i*DATA_W +: DATA_W];
        end
      end
      busy     <= busy_next;
      busy_cnt <= busy_cnt_next;
    end
  end

  assign o_busy_cnt = busy_cnt;

  // Combinational read ports. With bypass, a register written this cycle
  // shows its winning write data and is reported not busy, unless the
  // same cycle also allocates it, in which case the registered busy bit
  // is reported.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_read
    logic [ADDR_W-1:0] rd_a;
    assign rd_a = i_rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      o_rd_data[k*DATA_W +: DATA_W] = regs[rd_a];
      o_rd_busy[k]                  = busy[rd_a];
      if (BYPASS && wen_vec[rd_a]) begin
        o_rd_data[k*DATA_W +: DATA_W] = wdata_flat[rd_a*DATA_W +: DATA_W];
        if (!(alloc_valid && (i_alloc_addr == rd_a))) begin
          o_rd_busy[k] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Self-checking bench for regfile_mp_scoreboard. Two instances share the
// same stimulus: one with write-to-read bypass, one without. Stimulus
// pushes hand-computed expectations into a queue; a monitor on the
// falling edge pops and compares them against the live outputs.
module tb_regfile_mp_scoreboard;
   import regfile_pkg::*;

   typedef enum logic [1:0] {K_DATA, K_BUSY, K_CNT} kind_e;

   typedef struct {
      string       name;
      kind_e       kind;
      int          dut;
      int          port;
      logic [31:0] exp_val;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [1:0]  wr_wren;
   logic        alloc_en;
   reg_addr_t   alloc_addr;
   logic        flush;

   logic [63:0] rd_data_byp;
   logic [1:0]  rd_busy_byp;
   logic [5:0]  busy_cnt_byp;
   logic [63:0] rd_data_nob;
   logic [1:0]  rd_busy_nob;
   logic [5:0]  busy_cnt_nob;

   exp_t sb_q[$];
   exp_t item;
   int   n_checks;
   int   n_fail;
   logic stim_done;

   regfile_mp_scoreboard #(
      .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .NUM_WR (2), .BYPASS (1'b1)
   ) dut_byp (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rd_addr    (rd_addr),
      .o_rd_data    (rd_data_byp),
      .o_rd_busy    (rd_busy_byp),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .i_wr_wren    (wr_wren),
      .i_alloc_en   (alloc_en),
      .i_alloc_addr (alloc_addr),
      .i_flush      (flush),
      .o_busy_cnt   (busy_cnt_byp)
   );

   regfile_mp_scoreboard #(
      .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .NUM_WR (2), .BYPASS (1'b0)
   ) dut_nob (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rd_addr    (rd_addr),
      .o_rd_data    (rd_data_nob),
      .o_rd_busy    (rd_busy_nob),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .i_wr_wren    (wr_wren),
      .i_alloc_en   (alloc_en),
      .i_alloc_addr (alloc_addr),
      .i_flush      (flush),
      .o_busy_cnt   (busy_cnt_nob)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Selects the DUT output an expectation refers to
   function automatic logic [31:0] getActual(input exp_t e);
      logic [31:0] v;
      v = '0;
      case (e.kind)
         K_DATA: v = (e.dut == 0) ? rd_data_byp[e.port*32 +: 32] : rd_data_nob[e.port*32 +: 32];
         K_BUSY: v = {31'b0, (e.dut == 0) ? rd_busy_byp[e.port] : rd_busy_nob[e.port]};
         K_CNT:  v = {26'b0, (e.dut == 0) ? busy_cnt_byp : busy_cnt_nob};
         default: v = '0;
      endcase
      return v;
   endfunction

   // Monitor: drains every queued expectation at each falling edge, which
   // sits half a cycle away from the rising edge that updates state.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         item = sb_q.pop_front();
         n_checks++;
         if (getActual(item) !== item.exp_val) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, getActual(item), item.exp_val);
         end
      end
      if (stim_done) begin
         $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
   end

   // Hard stop in case the stimulus ever stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input kind_e kind, input int dut,
                              input int port, input logic [31:0] exp_val);
      exp_t e;
      e.name    = name;
      e.kind    = kind;
      e.dut     = dut;
      e.port    = port;
      e.exp_val = exp_val;
      sb_q.push_back(e);
   endtask

   task automatic checkBoth(input string name, input kind_e kind, input int port,
                            input logic [31:0] exp_val);
      checkOutput({name, "_byp"}, kind, 0, port, exp_val);
      checkOutput({name, "_nob"}, kind, 1, port, exp_val);
   endtask

   task automatic applyStimulus(input logic [1:0] wren,
                                input reg_addr_t wa0, input reg_data_t wd0,
                                input reg_addr_t wa1, input reg_data_t wd1,
                                input logic aen, input reg_addr_t aaddr,
                                input logic fl,
                                input reg_addr_t ra0, input reg_addr_t ra1);
      wr_wren    = wren;
      wr_addr    = {wa1, wa0};
      wr_data    = {wd1, wd0};
      alloc_en   = aen;
      alloc_addr = aaddr;
      flush      = fl;
      rd_addr    = {ra1, ra0};
   endtask

   task automatic idle(input reg_addr_t ra0, input reg_addr_t ra1);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, ra0, ra1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      stim_done = 1'b0;
      rst       = 1'b1;
      idle(5'd0, 5'd0);
      step();
      step();
      rst = 1'b0;

      // Reset state
      idle(5'd5, 5'd7);
      checkBoth("rst_data0", K_DATA, 0, 32'h0);
      checkBoth("rst_data1", K_DATA, 1, 32'h0);
      checkBoth("rst_busy0", K_BUSY, 0, 32'h0);
      checkBoth("rst_cnt",   K_CNT,  0, 32'h0);
      #3;
      n_checks++;
      if (rd_data_byp[31:0] !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL rst_direct: got 0x%0h, expected 0x0", rd_data_byp[31:0]);
      end
      step();

      // Collision on x7: port1 wins
      applyStimulus(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
      checkOutput("coll_bypass_byp", K_DATA, 0, 0, 32'h2222);
      checkOutput("coll_bypass_nob", K_DATA, 1, 0, 32'h0);
      step();
      idle(5'd7, 5'd0);
      checkBoth("coll_after", K_DATA, 0, 32'h2222);
      checkBoth("coll_x0",    K_DATA, 1, 32'h0);
      #3;
      n_checks++;
      if (rd_data_byp[31:0] !== 32'h2222) begin
         n_fail++;
         $display("[TB] FAIL coll_direct_byp: got 0x%0h, expected 0x2222", rd_data_byp[31:0]);
      end
      n_checks++;
      if (rd_data_nob[31:0] !== 32'h2222) begin
         n_fail++;
         $display("[TB] FAIL coll_direct_nob: got 0x%0h, expected 0x2222", rd_data_nob[31:0]);
      end
      step();

      // Bypass: old x3 = 0x5555, then write 0xABCD while reading
      applyStimulus(2'b01, 5'd3, 32'h5555, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      step();
      applyStimulus(2'b01, 5'd3, 32'hABCD, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
      checkOutput("byp_same_byp", K_DATA, 0, 0, 32'hABCD);
      checkOutput("byp_same_nob", K_DATA, 1, 0, 32'h5555);
      step();
      idle(5'd0, 5'd3);
      checkBoth("byp_next", K_DATA, 1, 32'hABCD);
      step();

      // x0: write and alloc ignored
      applyStimulus(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
      checkBoth("x0_data_same", K_DATA, 0, 32'h0);
      checkBoth("x0_busy_same", K_BUSY, 0, 32'h0);
      step();
      idle(5'd0, 5'd0);
      checkBoth("x0_data", K_DATA, 0, 32'h0);
      checkBoth("x0_busy", K_BUSY, 0, 32'h0);
      checkBoth("x0_cnt",  K_CNT,  0, 32'h0);
      step();

      // Scoreboard: alloc x4, x9
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 5'd0);
      step();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
      step();
      // Count is 2; write x4 on port1 this cycle
      applyStimulus(2'b10, 5'd0, 32'h0, 5'd4, 32'h44, 1'b0, 5'd0, 1'b0, 5'd4, 5'd9);
      checkBoth("sb_cnt2", K_CNT, 0, 32'd2);
      checkOutput("sb_busy4_wr_byp", K_BUSY, 0, 0, 32'h0);
      checkOutput("sb_busy4_wr_nob", K_BUSY, 1, 0, 32'h1);
      checkBoth("sb_busy9", K_BUSY, 1, 32'h1);
      checkOutput("sb_data4_wr_byp", K_DATA, 0, 0, 32'h44);
      checkOutput("sb_data4_wr_nob", K_DATA, 1, 0, 32'h0);
      step();
      // Count is 1; alloc x9 and write x9 on the same edge
      applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd4);
      checkBoth("sb_cnt1",   K_CNT,  0, 32'd1);
      checkBoth("sb_busy4",  K_BUSY, 1, 32'h0);
      checkBoth("sb_data4",  K_DATA, 1, 32'h44);
      checkBoth("sb_busy9a", K_BUSY, 0, 32'h1);
      step();
      // Re-alloc an already-busy x9: count unchanged
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd4);
      checkBoth("sb_busy9b", K_BUSY, 0, 32'h1);
      checkBoth("sb_data9",  K_DATA, 0, 32'h99);
      checkBoth("sb_cnt1b",  K_CNT,  0, 32'd1);
      step();
      idle(5'd9, 5'd0);
      checkBoth("sb_realloc_cnt", K_CNT, 0, 32'd1);
      step();

      // Flush: x9, x10, x11 busy, then flush with alloc x12
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, 5'd0, 5'd0);
      step();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd11, 1'b0, 5'd0, 5'd0);
      step();
      idle(5'd10, 5'd11);
      checkBoth("fl_cnt3",   K_CNT,  0, 32'd3);
      checkBoth("fl_busy10", K_BUSY, 0, 32'h1);
      checkBoth("fl_busy11", K_BUSY, 1, 32'h1);
      step();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd12, 5'd9);
      checkBoth("fl_busy12_pre", K_BUSY, 0, 32'h0);
      step();
      idle(5'd12, 5'd9);
      checkBoth("fl_cnt1",   K_CNT,  0, 32'd1);
      checkBoth("fl_busy12", K_BUSY, 0, 32'h1);
      checkBoth("fl_busy9",  K_BUSY, 1, 32'h0);
      #3;
      n_checks++;
      if (busy_cnt_byp !== 6'd1) begin
         n_fail++;
         $display("[TB] FAIL fl_direct_cnt: got %0d, expected 1", busy_cnt_byp);
      end
      step();

      // Reset mid-cycle aborts an in-flight write of x5 and alloc of x5
      applyStimulus(2'b01, 5'd5, 32'hDEAD, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd3);
      #2;
      rst = 1'b1;
      #1;
      idle(5'd5, 5'd3);
      checkBoth("mrst_data5", K_DATA, 0, 32'h0);
      checkBoth("mrst_data3", K_DATA, 1, 32'h0);
      checkBoth("mrst_cnt",   K_CNT,  0, 32'h0);
      step();
      rst = 1'b0;
      idle(5'd5, 5'd12);
      checkBoth("mrst_data5b", K_DATA, 0, 32'h0);
      checkBoth("mrst_busy5",  K_BUSY, 0, 32'h0);
      checkBoth("mrst_busy12", K_BUSY, 1, 32'h0);
      checkBoth("mrst_cntb",   K_CNT,  0, 32'h0);
      step();

      stim_done = 1'b1;
   end

endmodule
